// File: rtl/alu_seq_mdu.sv
// Multi-cycle unsigned MUL / DIVU sequencer that borrows the datapath ALU.
// One shift-add or restoring-divide step per cycle, WIDTH steps per operation.
module alu_seq_mdu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b1010;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_op;
  logic [WIDTH-1:0]   r_x;    // MUL: multiplicand, DIVU: dividend/quotient shift register
  logic [WIDTH-1:0]   r_y;    // MUL: multiplier,   DIVU: divisor
  logic [WIDTH-1:0]   r_acc;  // MUL: accumulator,  DIVU: partial remainder
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH-1:0]   w_rem_sh;
  logic               w_ge;
  logic [WIDTH-1:0]   w_acc_nxt;
  logic [WIDTH-1:0]   w_x_nxt;
  logic [WIDTH-1:0]   w_y_nxt;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_CHECK;
      S_CHECK: w_state_nxt = (r_op && alu_zero) ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == CNT_W'(WIDTH - 1)) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ALU drive per state
  always_comb begin
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = CTRL_AND;
    case (r_state)
      S_CHECK: begin
        alu_a    = r_y;
        alu_ctrl = CTRL_OR;
      end
      S_RUN: begin
        if (r_op) begin
          alu_a    = w_rem_sh;
          alu_b    = r_y;
          alu_ctrl = CTRL_SUB;
        end else begin
          alu_a    = r_acc;
          alu_b    = r_x;
          alu_ctrl = CTRL_ADD;
        end
      end
      default: ;
    endcase
  end

  // One iteration step; the ge test recovers the borrow the ALU does not expose
  always_comb begin
    w_rem_sh = {r_acc[WIDTH-2:0], r_x[WIDTH-1]};
    w_ge     = r_acc[WIDTH-1] |
               ((w_rem_sh[WIDTH-1] == r_y[WIDTH-1]) ? ~alu_result[WIDTH-1] : w_rem_sh[WIDTH-1]);
    if (r_op) begin
      w_acc_nxt = w_ge ? alu_result : w_rem_sh;
      w_x_nxt   = {r_x[WIDTH-2:0], w_ge};
      w_y_nxt   = r_y;
    end else begin
      w_acc_nxt = r_y[0] ? alu_result : r_acc;
      w_x_nxt   = r_x << 1;
      w_y_nxt   = r_y >> 1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_op      <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      busy <= (w_state_nxt == S_CHECK) || (w_state_nxt == S_RUN);
      done <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: if (start) begin
          r_op <= op;
          r_x  <= src_a;
          r_y  <= src_b;
        end
        S_CHECK: begin
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_RUN: begin
          r_acc <= w_acc_nxt;
          r_x   <= w_x_nxt;
          r_y   <= w_y_nxt;
          r_cnt <= r_cnt + CNT_W'(1);
        end
        default: ;
      endcase
      // Results change only on entry to DONE
      if (w_state_nxt == S_DONE) begin
        if (r_state == S_CHECK) begin
          result_lo <= '1;
          result_hi <= r_x;
        end else if (r_op) begin
          result_lo <= w_x_nxt;
          result_hi <= w_acc_nxt;
        end else begin
          result_lo <= w_acc_nxt;
          result_hi <= '0;
        end
      end
    end
  end

endmodule
